// File: rtl/merge16_sequencer.sv
`default_nettype none
// ============================================================================
// merge16_sequencer : packs two sorted 8-key runs for the odd-even merge
//                     network, captures the merged frame and streams it out.
// Revision: 1.0
// ============================================================================
module merge16_sequencer #(
    parameter int WIDTH = 3,
    parameter int N     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 in_ready,
    input  logic                 abort,
    output logic [2*N*WIDTH-1:0] inba,
    input  logic [2*N*WIDTH-1:0] c,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 order_err,
    output logic [7:0]           frames_done
);

    localparam int FRAME = 2 * N;
    localparam int IDX_W = $clog2(FRAME);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME - 1);
    localparam logic [IDX_W-1:0] RUN_B_IDX = IDX_W'(N);

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] slot_q   [FRAME];
    logic [WIDTH-1:0] slot_d   [FRAME];
    logic [WIDTH-1:0] result_q [FRAME];
    logic [WIDTH-1:0] result_d [FRAME];
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             order_err_q, order_err_d;
    logic [7:0]       frames_q, frames_d;
    logic             live_q;
    logic             in_fire;
    logic             out_fire;

    // live_q keeps in_ready low until the first edge after reset release.
    assign in_ready    = live_q && (state_q == LOAD);
    assign out_valid   = (state_q == DRAIN);
    assign out_data    = out_valid ? result_q[idx_q] : '0;
    assign out_last    = out_valid && (idx_q == LAST_IDX);
    assign order_err   = order_err_q;
    assign frames_done = frames_q;
    assign in_fire     = in_valid && in_ready;
    assign out_fire    = out_valid && out_ready;

    for (genvar k = 0; k < FRAME; k++) begin : g_pack
        assign inba[k*WIDTH +: WIDTH] = slot_q[k];
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        slot_d      = slot_q;
        result_d    = result_q;
        prev_d      = prev_q;
        order_err_d = order_err_q;
        frames_d    = frames_q;

        if (abort) begin
            state_d     = LOAD;
            idx_d       = '0;
            order_err_d = 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (in_fire) begin
                        slot_d[idx_q] = in_data;
                        prev_d        = in_data;
                        // First key of each run starts a fresh ordering check.
                        if (idx_q == '0) begin
                            order_err_d = 1'b0;
                        end else if ((idx_q != RUN_B_IDX) && (in_data < prev_q)) begin
                            order_err_d = 1'b1;
                        end
                        if (idx_q == LAST_IDX) begin
                            idx_d   = '0;
                            state_d = SETTLE;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    state_d = CAPTURE;
                end
                CAPTURE: begin
                    for (int k = 0; k < FRAME; k++) begin
                        result_d[k] = c[k*WIDTH +: WIDTH];
                    end
                    state_d = DRAIN;
                end
                DRAIN: begin
                    if (out_fire) begin
                        if (idx_q == LAST_IDX) begin
                            idx_d    = '0;
                            state_d  = LOAD;
                            frames_d = frames_q + 8'd1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = LOAD;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= LOAD;
            idx_q       <= '0;
            prev_q      <= '0;
            order_err_q <= 1'b0;
            frames_q    <= 8'd0;
            live_q      <= 1'b0;
            for (int k = 0; k < FRAME; k++) begin
                slot_q[k]   <= '0;
                result_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            prev_q      <= prev_d;
            order_err_q <= order_err_d;
            frames_q    <= frames_d;
            live_q      <= 1'b1;
            slot_q      <= slot_d;
            result_q    <= result_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/merge16_sequencer.md
# merge16_sequencer

Frame sequencer for the 16-key odd-even merge network, which merges two sorted 8-key runs into one 16-key result. The sequencer accepts keys serially over a valid/ready stream and packs them into the network's A and B run slots. It holds the packed word stable while the network settles, captures the merged result, and streams the 16 sorted keys out over a second valid/ready stream. It sits between the V2V record ingress and the downstream consumer and owns the network's input/output timing.

## Interface
- WIDTH, 3, key width in bits
- n, 8, keys per run; frame = 2*n keys (only n=8 supported)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  input key valid
- in_data  in  WIDTH  input key
- in_ready  out  1  sequencer accepts key
- abort  in  1  synchronous frame discard
- inba  out  2*n*WIDTH  packed runs to merge network: slot k at bits [(k+1)*WIDTH-1:k*WIDTH]; slots 0..7 = run A, 8..15 = run B
- c  in  2*n*WIDTH  merged result from network, slot 0 = smallest
- out_valid  out  1  output key valid
- out_data  out  WIDTH  output key
- out_ready  in  1  consumer accepts key
- out_last  out  1  marks 16th output key of frame
- order_err  out  1  sticky: current frame's run A or B was not non-decreasing
- frames_done  out  8  count of fully drained frames, wraps 255->0

## Operation
- States: LOAD, SETTLE, CAPTURE, DRAIN. Reset state LOAD.
- LOAD:
  - in_ready=1; each handshake (in_valid&in_ready) writes in_data into inba slot idx, then idx++.
  - idx is 4-bit, 0..15.
  - Handshake at idx=15 -> SETTLE, idx=0.
- SETTLE: inba held; one cycle for the combinational network -> CAPTURE.
- CAPTURE: result register <= c -> DRAIN.
- DRAIN:
  - out_valid=1; out_data = result slot idx; out_last=(idx==15).
  - Each out handshake increments idx.
  - Handshake with out_last -> LOAD, idx=0, frames_done++.
- inba changes only on LOAD handshakes; stable through SETTLE/CAPTURE/DRAIN.
- Order check, per run, on LOAD handshakes:
  - Applies to idx 1..7 and 9..15: set order_err if in_data < previously accepted key (unsigned).
  - No comparison at idx 0 or 8; run boundary not checked.
  - Cleared by the handshake at idx 0 of the next frame (that key's own check is skipped).
  - order_err does not stop sorting; the network output is passed through unchanged.
- abort=1 in any state:
  - Next state LOAD, idx=0, out_valid drops next cycle, frames_done unchanged.
  - abort wins over a same-cycle in or out handshake; that key is dropped/not counted.
  - order_err cleared; inba contents retained, overwritten by the next frame.
- out_data and out_last hold stable while out_valid&!out_ready.

## Timing
- Reset values (asserted while rst low, immediately):
  - state=LOAD, idx=0, inba=0, result=0, out_valid=0, out_data=0, out_last=0, order_err=0, frames_done=0.
  - in_ready forced 0 while rst low; 1 from the first clock edge after release.
- Reset mid-frame discards all partial state; no output of partial frames.
- Latency: 16th input handshake at cycle T -> SETTLE at T+1, CAPTURE at T+2, out_valid=1 at T+3.
- With out_ready=1 throughout, the frame drains in 16 cycles. in_ready returns on the cycle after the out_last handshake.
- Frame period with both sides unstalled: 16+2+16 = 34 cycles. No overlap of LOAD with DRAIN.
- in_ready=0 and out_valid=0 during SETTLE/CAPTURE.
- out_valid=0 in LOAD; in_ready=0 in DRAIN.
- The merge network is purely combinational; its path from inba to c must close within one clock (SETTLE) plus setup into the result register.

## Test plan
- Basic merge: A=0,1,1,3,4,5,6,7; B=0,2,2,3,3,5,7,7, in_valid held 1.
  - Out = 0,0,1,1,2,2,3,3,3,4,5,5,6,7,7,7.
  - out_valid rises 3 cycles after the 16th accept; out_last only on the final 7.
  - order_err=0; frames_done=1.
- Backpressure: same frame, out_ready alternating 1/0 from DRAIN entry.
  - out_data unchanged on every stalled cycle; exactly 16 handshakes in 31 cycles.
  - in_ready=1 the cycle after the last handshake.
- Input gaps and order error: in_valid toggled randomly; A keys 4,5 given as 5,2.
  - order_err=1 from the cycle after key 2 is accepted, held through DRAIN.
  - Cleared after the first accept of a clean next frame.
  - Keys that are sorted within each run but B < A across the boundary do not flag.
- Abort: abort pulsed in DRAIN after 5 output handshakes.
  - Next cycle: out_valid=0, in_ready=1, frames_done unchanged.
  - A new full frame then produces its correct 16 outputs.
- Async reset: rst low mid-LOAD after 10 keys, released between edges.
  - All outputs at reset values immediately; in_ready=0 while low.
  - The following frame sorts correctly with idx starting at 0.
- Counter wrap: 256 back-to-back frames -> frames_done reads 255 after frame 255, 0 after frame 256.
